ccff_chain_loader: RTL and testbench

Sequencer for the configuration-chain flip-flops (ccff) of the routing blocks: it takes bitstream words over a valid/ready handshake, serializes them MSB-first onto `ccff_head`, and produces one shift-enable per bit so the chain advances exactly `CHAIN_LEN` times. It also provides a self-test mode that loads an alternating pattern, flushes it, and checks `ccff_tail`. The block sits between the bitstream source and the head of each connection-block/switch-block ccff chain. `shift_en` drives the clock-gate enable of that chain.

---
 rtl/ccff_chain_loader.sv | 174 +++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes bitstream words MSB-first onto the ccff chain
// head with one shift enable per bit, plus an alternating-pattern chain self-test.
module ccff_chain_loader #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = 48,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              test,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int unsigned REM_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN2_C = CNT_W'(2 * CHAIN_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TEST_FILL,
    S_TEST_FLUSH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              head_d, shift_d, ready_d, busy_d, done_d, error_d;
  logic [CNT_W-1:0]  cnt_d, issued, issued_next;
  logic              abort_hit, accept, last_len, last_flush, flush_bit;

  // issued = shifts completed plus the bit currently presented on ccff_head
  assign issued     = bit_count + CNT_W'(shift_en);
  assign abort_hit  = abort && (state_q != S_IDLE);
  assign accept     = cfg_ready && cfg_valid;
  assign last_len   = shift_en && (bit_count == LEN_C - CNT_W'(1));
  assign last_flush = shift_en && (bit_count == LEN2_C - CNT_W'(1));
  // pattern index of the bit now at the tail is bit_count - CHAIN_LEN; only its LSB matters
  assign flush_bit  = bit_count[0] ^ LEN_C[0];

  // State register
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort_hit) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) state_d = test ? S_TEST_FILL : S_LOAD;
        S_LOAD:         if (last_len) state_d = S_DONE;
        S_TEST_FILL:    if (last_len) state_d = S_TEST_FLUSH;
        S_TEST_FLUSH:   if (last_flush) state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the datapath and registered outputs
  always_comb begin
    hold_d      = hold_q;
    rem_d       = rem_q;
    head_d      = ccff_head;
    shift_d     = 1'b0;
    ready_d     = 1'b0;
    cnt_d       = bit_count + CNT_W'(shift_en);
    done_d      = done;
    error_d     = error;
    issued_next = '0;
    busy_d      = (state_d == S_LOAD) || (state_d == S_TEST_FILL) ||
                  (state_d == S_TEST_FLUSH);
    if (abort_hit) begin
      hold_d  = '0;
      rem_d   = '0;
      error_d = 1'b1;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt_d   = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
            hold_d  = '0;
            rem_d   = '0;
            if (test) begin
              shift_d = 1'b1;
              head_d  = 1'b1;
            end else begin
              ready_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (rem_q != '0) begin
            if (issued < LEN_C) begin
              head_d  = hold_q[WORD_W-1];
              hold_d  = hold_q << 1;
              rem_d   = rem_q - REM_W'(1);
              shift_d = 1'b1;
            end else begin
              // chain full: drop the rest of a partial last word
              hold_d = '0;
              rem_d  = '0;
            end
          end else if (accept) begin
            head_d  = cfg_data[WORD_W-1];
            hold_d  = cfg_data << 1;
            rem_d   = REM_W'(WORD_W - 1);
            shift_d = 1'b1;
          end
          issued_next = cnt_d + CNT_W'(shift_d);
          ready_d = (state_d == S_LOAD) && (rem_d == '0) && (issued_next < LEN_C);
          if (state_d == S_DONE) done_d = 1'b1;
        end
        S_TEST_FILL, S_TEST_FLUSH: begin
          if (issued < LEN2_C) begin
            shift_d = 1'b1;
            head_d  = (issued < LEN_C) ? ~issued[0] : 1'b0;
          end
          if ((state_q == S_TEST_FLUSH) && shift_en && (ccff_tail != ~flush_bit))
            error_d = 1'b1;
          if (state_d == S_DONE) done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      hold_q    <= '0;
      rem_q     <= '0;
      ccff_head <= 1'b0;
      shift_en  <= 1'b0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      bit_count <= '0;
    end else begin
      hold_q    <= hold_d;
      rem_q     <= rem_d;
      ccff_head <= head_d;
      shift_en  <= shift_d;
      cfg_ready <= ready_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      bit_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: expected head bits are queued by the stimulus
// and popped by per-instance monitors on every shift_en cycle.
module tb_ccff_chain_loader;
  localparam int unsigned L = 48;

  logic        prog_clk = 1'b0;
  logic        pReset_n = 1'b0;
  logic        start = 1'b0, start2 = 1'b0, test = 1'b0, abort = 1'b0;
  logic [7:0]  cfg_data = 8'h00;
  logic        cfg_valid = 1'b0;
  logic        ccff_tail;
  logic        tail2 = 1'b0;
  logic        cfg_ready, ccff_head, shift_en, busy, done, error;
  logic [15:0] bit_count;
  logic        cfg_ready2, head2, shift2, busy2, done2, error2;
  logic [15:0] bit_count2;

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(L), .CNT_W(16)) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .test(test), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .shift_en(shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .error(error), .bit_count(bit_count));

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(12), .CNT_W(16)) dut2 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start2), .test(test), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .ccff_head(head2), .shift_en(shift2), .ccff_tail(tail2),
    .busy(busy2), .done(done2), .error(error2), .bit_count(bit_count2));

  always #5 prog_clk = ~prog_clk;

  // Chain model: shifts on the edge ending a shift_en cycle; stuck_mask forces flops to 0
  logic [L-1:0] chain = '0;
  logic [L-1:0] stuck_mask = '0;
  always @(posedge prog_clk) if (shift_en) chain <= {chain[L-2:0], ccff_head} & ~stuck_mask;
  assign ccff_tail = chain[L-1];

  int checks = 0, errors = 0, cyc = 0;
  int shifts1 = 0, shifts2 = 0, first1 = -1, last1 = -1;
  bit q1[$];
  bit q2[$];
  bit stop_send = 1'b0;

  initial begin : mon1
    bit e;
    forever begin
      @(negedge prog_clk);
      cyc++;
      if (pReset_n && shift_en) begin
        shifts1++;
        if (first1 < 0) first1 = cyc;
        last1 = cyc;
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL head1 unexpected shift got %0b", ccff_head);
        end else begin
          e = q1.pop_front();
          if (ccff_head !== e) begin
            errors++;
            $display("FAIL head1 shift %0d got %0b want %0b", shifts1, ccff_head, e);
          end
        end
      end
    end
  end

  initial begin : mon2
    bit e;
    forever begin
      @(negedge prog_clk);
      if (pReset_n && shift2) begin
        shifts2++;
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL head2 unexpected shift got %0b", head2);
        end else begin
          e = q2.pop_front();
          if (head2 !== e) begin
            errors++;
            $display("FAIL head2 shift %0d got %0b want %0b", shifts2, head2, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input bit sel, input logic [7:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (sel) q2.push_back(w[7-i]);
      else     q1.push_back(w[7-i]);
    end
  endtask

  task automatic pulse_start(input bit sel, input bit t);
    test = t;
    if (sel) start2 = 1'b1;
    else     start  = 1'b1;
    @(negedge prog_clk);
    start  = 1'b0;
    start2 = 1'b0;
    test   = 1'b0;
  endtask

  // Waits for an empty holding register, idles gap cycles, then hands one word over
  task automatic send_word(input bit sel, input logic [7:0] w, input int gap);
    int n;
    n = 0;
    cfg_valid = 1'b0;
    while (!(sel ? cfg_ready2 : cfg_ready) && n < 200 && !stop_send) begin
      @(negedge prog_clk);
      n++;
    end
    if (stop_send) return;
    chk("send_ready_wait", 64'(n < 200), 64'd1);
    for (int g = 0; g < gap; g++) begin
      @(negedge prog_clk);
      chk("stall_shift_en", 64'(shift_en), 64'd0);
    end
    cfg_data  = w;
    cfg_valid = 1'b1;
    @(negedge prog_clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int n;
    n = 0;
    while (!(sel ? done2 : done) && n < 500) begin
      @(negedge prog_clk);
      n++;
    end
    chk("wait_done", 64'(sel ? done2 : done), 64'd1);
  endtask

  task automatic run_selftest(input logic [L-1:0] mask, input bit exp_err);
    stuck_mask = mask;
    shifts1 = 0;
    for (int k = 0; k < int'(L); k++) q1.push_back(~k[0]);
    for (int k = 0; k < int'(L); k++) q1.push_back(1'b0);
    pulse_start(1'b0, 1'b1);
    chk("test_busy_t1", 64'(busy), 64'd1);
    chk("test_shift_t1", 64'(shift_en), 64'd1);
    repeat (95) @(negedge prog_clk);
    chk("test_done_t96", 64'(done), 64'd0);
    chk("test_shift_t96", 64'(shift_en), 64'd1);
    @(negedge prog_clk);
    chk("test_done_t97", 64'(done), 64'd1);
    chk("test_error", 64'(error), 64'(exp_err));
    chk("test_bit_count", 64'(bit_count), 64'd96);
    chk("test_shifts", 64'(shifts1), 64'd96);
    chk("test_shift_off", 64'(shift_en), 64'd0);
    stuck_mask = '0;
  endtask

  logic [7:0]  words [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
  logic [47:0] chain_exp = 48'hA53CFF00817E;
  logic [L-1:0] stuck10 = '0;

  initial begin : stim
    int n;
    repeat (3) @(negedge prog_clk);
    chk("reset_outs", 64'({cfg_ready, ccff_head, shift_en, busy, done, error}), 64'd0);
    chk("reset_bit_count", 64'(bit_count), 64'd0);
    pReset_n = 1'b1;
    @(negedge prog_clk);

    // gap-free load
    shifts1 = 0; first1 = -1;
    for (int i = 0; i < 6; i++) push_word(1'b0, words[i], 8);
    pulse_start(1'b0, 1'b0);
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_ready", 64'(cfg_ready), 64'd1);
    for (int i = 0; i < 6; i++) send_word(1'b0, words[i], 0);
    wait_done(1'b0);
    chk("load_shifts", 64'(shifts1), 64'd48);
    chk("load_gapfree_span", 64'(last1 - first1), 64'd47);
    chk("load_bit_count", 64'(bit_count), 64'd48);
    chk("load_error", 64'(error), 64'd0);
    chk("load_ready_done", 64'(cfg_ready), 64'd0);
    chk("load_busy_done", 64'(busy), 64'd0);
    chk("load_chain", 64'(chain), 64'(chain_exp));
    chk("load_queue_empty", 64'(q1.size()), 64'd0);

    // stalled load, 3 idle cycles between words
    shifts1 = 0; first1 = -1;
    for (int i = 0; i < 6; i++) push_word(1'b0, words[i], 8);
    pulse_start(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_word(1'b0, words[i], (i == 0) ? 0 : 3);
    wait_done(1'b0);
    chk("stall_shifts", 64'(shifts1), 64'd48);
    chk("stall_span", 64'(last1 - first1), 64'd62);
    chk("stall_bit_count", 64'(bit_count), 64'd48);
    chk("stall_chain", 64'(chain), 64'(chain_exp));

    // partial last word on the 12-flop instance
    shifts2 = 0;
    push_word(1'b1, 8'hF0, 8);
    push_word(1'b1, 8'h0F, 4);
    pulse_start(1'b1, 1'b0);
    send_word(1'b1, 8'hF0, 0);
    send_word(1'b1, 8'h0F, 0);
    wait_done(1'b1);
    chk("partial_shifts", 64'(shifts2), 64'd12);
    chk("partial_bit_count", 64'(bit_count2), 64'd12);
    chk("partial_error", 64'(error2), 64'd0);
    chk("partial_busy", 64'(busy2), 64'd0);
    cfg_data = 8'h55;
    cfg_valid = 1'b1;
    repeat (4) begin
      @(negedge prog_clk);
      chk("partial_ready_low", 64'(cfg_ready2), 64'd0);
    end
    cfg_valid = 1'b0;
    chk("partial_queue_empty", 64'(q2.size()), 64'd0);

    // self-test on a good chain, then with flop 10 stuck at 0
    run_selftest('0, 1'b0);
    stuck10[10] = 1'b1;
    run_selftest(stuck10, 1'b1);

    // abort mid-load, with an ignored start pulse during LOAD
    q1.delete();
    shifts1 = 0;
    for (int i = 0; i < 3; i++) push_word(1'b0, words[i], 8);
    pulse_start(1'b0, 1'b0);
    chk("abort_start_clears_error", 64'(error), 64'd0);
    fork
      begin
        for (int i = 0; i < 3; i++) send_word(1'b0, words[i], 0);
      end
    join_none
    n = 0;
    while (bit_count != 16'd5 && n < 200) begin @(negedge prog_clk); n++; end
    start = 1'b1; test = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; test = 1'b0;
    chk("ignored_start_count", 64'(bit_count), 64'd6);
    chk("ignored_start_busy", 64'(busy), 64'd1);
    n = 0;
    while (!(bit_count == 16'd19 && shift_en) && n < 200) begin @(negedge prog_clk); n++; end
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    stop_send = 1'b1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_error", 64'(error), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_bit_count", 64'(bit_count), 64'd20);
    chk("abort_shift", 64'(shift_en), 64'd0);
    chk("abort_ready", 64'(cfg_ready), 64'd0);
    chk("abort_shifts", 64'(shifts1), 64'd20);
    repeat (2) @(negedge prog_clk);
    chk("abort_idle_shift", 64'(shift_en), 64'd0);
    stop_send = 1'b0;
    cfg_valid = 1'b0;
    q1.delete();

    // asynchronous reset in the middle of a load
    push_word(1'b0, 8'hFF, 8);
    pulse_start(1'b0, 1'b0);
    send_word(1'b0, 8'hFF, 0);
    repeat (2) @(negedge prog_clk);
    chk("prereset_head", 64'(ccff_head), 64'd1);
    #2 pReset_n = 1'b0;
    #1;
    chk("async_reset_outs", 64'({cfg_ready, ccff_head, shift_en, busy, done, error}), 64'd0);
    chk("async_reset_count", 64'(bit_count), 64'd0);
    q1.delete();
    @(negedge prog_clk);
    pReset_n = 1'b1;
    @(negedge prog_clk);
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_ready", 64'(cfg_ready), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
